uart_rx: RTL and testbench

//   16x-oversampled UART receiver, 8N1 framing by default.

---
 rtl/uart_rx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receiver with held-byte valid/read handshake
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity cell, frame becomes 8E1)
//
// Ports:
//   clock          system clock (also drives the baud generator)
//   reset_n        asynchronous active-low reset
//   uart_tick_16x  one-clock pulse at 16x the baud rate
//   rx             serial input, idle high, asynchronous to clock
//   read           consumer acknowledge, clears data_ready
//   data           last committed byte
//   data_ready     byte available, held until read
//   framing_error  stop bit sampled 0 for the byte in data
//   overrun        sticky, a byte was lost while data_ready was set
//   parity_error   parity mismatch for the byte in data (UART_RX_PARITY_EN only)

module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 uart_tick_16x,
    input  logic                 rx,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 overrun
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rxs;
    logic [2:0]           hist;
    logic                 vote3;
    logic [3:0]           cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 commit_pend;
    logic                 stop_fe;
    logic                 mid;
    logic                 last_bit;
    logic                 in_frame;
    logic                 bit_first;
    logic                 bit_take;
    logic                 stop_take;
`ifdef UART_RX_PARITY_EN
    logic                 par_take;
    logic                 par_err_q;
`endif

    // Synchroniser presets to 1 so a reset release never looks like a start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end
    assign rxs = sync_q[SYNC_STAGES-1];

    // Majority over the three most recent tick samples filters single-tick noise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 3'b111;
        end else if (uart_tick_16x) begin
            hist <= {hist[1:0], rxs};
        end
    end
    assign vote3 = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

    assign mid      = uart_tick_16x && (cnt == 4'd8);
    assign last_bit = (bit_idx == IDX_W'(DATA_BITS - 1));

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (uart_tick_16x && !rxs) state_d = ST_START;
            ST_START: if (mid) state_d = vote3 ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:  if (mid && last_bit) state_d = ST_PARITY;
            ST_PARITY: if (mid) state_d = ST_STOP;
`else
            ST_DATA:  if (mid && last_bit) state_d = ST_STOP;
`endif
            // Leaving at mid-stop lets the next start edge resynchronise the cell timing.
            ST_STOP:  if (mid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_frame  = (state != ST_IDLE);
        bit_first = (state == ST_START) && mid && !vote3;
        bit_take  = (state == ST_DATA) && mid;
        stop_take = (state == ST_STOP) && mid;
`ifdef UART_RX_PARITY_EN
        par_take  = (state == ST_PARITY) && mid;
`endif
    end

    // cnt runs freely through the frame; each bit cell starts where it wraps to 0,
    // so successive mid-cell samples at cnt==8 are exactly 16 ticks apart.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 4'd0;
        end else if (!in_frame) begin
            cnt <= 4'd0;
        end else if (uart_tick_16x) begin
            cnt <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx     <= '0;
            shreg       <= '0;
            commit_pend <= 1'b0;
            stop_fe     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            commit_pend <= stop_take;
            if (bit_first) begin
                bit_idx <= '0;
            end else if (bit_take) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (bit_take) begin
                shreg <= {vote3, shreg[DATA_BITS-1:1]};
            end
            if (stop_take) begin
                stop_fe <= ~vote3;
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to 0.
            if (par_take) begin
                par_err_q <= (^shreg) ^ vote3;
            end
`endif
        end
    end

    // Consumer side: a commit while an unread byte is held is dropped and flagged,
    // unless the read lands on the same edge, in which case the new byte replaces it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data          <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else if (commit_pend) begin
            if (data_ready && !read) begin
                overrun <= 1'b1;
            end else begin
                data          <= shreg;
                framing_error <= stop_fe;
                data_ready    <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_error  <= par_err_q;
`endif
                if (read) begin
                    overrun <= 1'b0;
                end
            end
        end else if (read && data_ready) begin
            data_ready <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with randomized frames

module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_tick_16x = 1'b0;
    logic       rx = 1'b1;
    logic       read = 1'b0;
    logic [7:0] data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass = 0;
    logic par_bit = 1'b0;
    logic mon_dr_p = 1'b0;
    logic mon_rd_p = 1'b0;

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .uart_tick_16x (uart_tick_16x),
        .rx            (rx),
        .read          (read),
        .data          (data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
        .parity_error  (parity_error),
`endif
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    // One tick every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clock);
            uart_tick_16x = 1'b1;
            @(negedge clock);
            uart_tick_16x = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            while (uart_tick_16x !== 1'b1) @(posedge clock);
            #1;
        end
    endtask

    task automatic do_read();
        read = 1'b1;
        @(posedge clock);
        #1 read = 1'b0;
    endtask

    // Drives one frame at 16 ticks per cell; optionally pulses read on the edge
    // one clock after the stop-bit mid-sample tick (10 ticks into the stop cell).
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit rd_at_commit);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        wait_ticks(16);
`endif
        rx = stop_b;
        if (rd_at_commit) begin
            wait_ticks(10);
            do_read();
            wait_ticks(6);
        end else begin
            wait_ticks(16);
        end
        rx = 1'b1;
        wait_ticks(12);
    endtask

    // Reference: byte as sent, framing error when stop is 0, even-parity mismatch.
    task automatic frame_exp(input logic [7:0] d, input logic stop_b, input logic pbit,
                             input bit rd_at_commit, input bit expect_it);
        exp_t e;
        par_bit = pbit;
        e.d  = d;
        e.fe = ~stop_b;
        e.pe = (^d) ^ pbit;
        if (expect_it) exp_q.push_back(e);
        send_frame(d, stop_b, rd_at_commit);
    endtask

    // Monitor: a new byte is present when data_ready rises, or stays high across a read edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mon_dr_p = 1'b0;
                mon_rd_p = 1'b0;
            end else begin
                if (data_ready && (!mon_dr_p || mon_rd_p)) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_byte: got %0h expected none", data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_data", {24'd0, data}, {24'd0, e.d});
                        chk("mon_framing_error", {31'd0, framing_error}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
                        chk("mon_parity_error", {31'd0, parity_error}, {31'd0, e.pe});
`endif
                    end
                end
                mon_dr_p = data_ready;
                mon_rd_p = read;
            end
        end
    end

    initial begin
        logic [7:0] rd;
        logic       rs;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_data", {24'd0, data}, 32'd0);
        chk("reset_data_ready", {31'd0, data_ready}, 32'd0);
        chk("reset_framing_error", {31'd0, framing_error}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        wait_ticks(4);

        // Glitch: 4 ticks low is a false start.
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
        chk("glitch_data_ready", {31'd0, data_ready}, 32'd0);
        chk("glitch_framing_error", {31'd0, framing_error}, 32'd0);
        chk("glitch_overrun", {31'd0, overrun}, 32'd0);

        frame_exp(8'h55, 1'b1, ^8'h55, 1'b0, 1'b1);
        chk("f55_data_ready", {31'd0, data_ready}, 32'd1);
        do_read();
        chk("f55_ready_cleared", {31'd0, data_ready}, 32'd0);

        frame_exp(8'hA3, 1'b0, ^8'hA3, 1'b0, 1'b1);
        chk("fa3_framing_error", {31'd0, framing_error}, 32'd1);
        do_read();

        // Overrun: second byte is dropped.
        frame_exp(8'h11, 1'b1, ^8'h11, 1'b0, 1'b1);
        frame_exp(8'h22, 1'b1, ^8'h22, 1'b0, 1'b0);
        chk("ovr_data_kept", {24'd0, data}, 32'h11);
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        do_read();
        chk("ovr_ready_cleared", {31'd0, data_ready}, 32'd0);
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Read coincides with the commit of the next byte.
        frame_exp(8'h40, 1'b1, ^8'h40, 1'b0, 1'b1);
        frame_exp(8'h7E, 1'b1, ^8'h7E, 1'b1, 1'b1);
        chk("coinc_data", {24'd0, data}, 32'h7E);
        chk("coinc_data_ready", {31'd0, data_ready}, 32'd1);
        chk("coinc_overrun", {31'd0, overrun}, 32'd0);

        // Reset during data bit 4 of 0xFF, byte left unread so reset must clear it.
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(16 * 4 + 8);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("midreset_data", {24'd0, data}, 32'd0);
        chk("midreset_data_ready", {31'd0, data_ready}, 32'd0);
        reset_n = 1'b1;
        wait_ticks(12);
        frame_exp(8'h3C, 1'b1, ^8'h3C, 1'b0, 1'b1);
        chk("after_reset_data", {24'd0, data}, 32'h3C);
        do_read();

        for (int i = 0; i < 10; i++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            frame_exp(rd, rs, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            chk("rand_data_ready", {31'd0, data_ready}, 32'd1);
            do_read();
        end

`ifdef UART_RX_PARITY_EN
        frame_exp(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("par_07_error", {31'd0, parity_error}, 32'd1);
        do_read();
`endif

        repeat (10) @(negedge clock);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
